// File: rtl/fft_r22sdf_wm_pipe_if.sv
// Bundle of the data/control signals around the twiddle multiplier.
//   master : producer side (drives x, w, ctr, conj, valid, ce, ovf_clr; reads results)
//   slave  : multiplier side (reads inputs, drives valid_o, ctr_o, z_re_o, z_im_o, ovf_o)
interface fft_r22sdf_wm_pipe_if #(
  parameter int DW            = 24,
  parameter int TWIDDLE_WIDTH = 10,
  parameter int NLOG2         = 10
);
  logic                            ce_i;
  logic                            valid_i;
  logic [NLOG2-1:0]                ctr_i;
  logic                            conj_i;
  logic signed [DW-1:0]            x_re_i;
  logic signed [DW-1:0]            x_im_i;
  logic signed [TWIDDLE_WIDTH-1:0] w_re_i;
  logic signed [TWIDDLE_WIDTH-1:0] w_im_i;
  logic                            ovf_clr_i;
  logic                            valid_o;
  logic [NLOG2-1:0]                ctr_o;
  logic signed [DW-1:0]            z_re_o;
  logic signed [DW-1:0]            z_im_o;
  logic                            ovf_o;

  modport master (
    output ce_i, valid_i, ctr_i, conj_i, x_re_i, x_im_i, w_re_i, w_im_i, ovf_clr_i,
    input  valid_o, ctr_o, z_re_o, z_im_o, ovf_o
  );

  modport slave (
    input  ce_i, valid_i, ctr_i, conj_i, x_re_i, x_im_i, w_re_i, w_im_i, ovf_clr_i,
    output valid_o, ctr_o, z_re_o, z_im_o, ovf_o
  );
endinterface

// File: rtl/fft_r22sdf_wm_pipe.sv
// Pipelined complex twiddle multiplier for R22SDF FFT stages: z = x * w or x * conj(w).
// Karatsuba form with three real multiplies; four enabled-cycle latency, one sample/cycle.
// Result is scaled by 2^-(TWIDDLE_WIDTH-1), optionally rounded half up, then saturated or
// wrapped to DW bits. A sticky flag records any valid result that left the DW range.
// Ports:
//   clk_i    clock
//   rst_n_i  asynchronous active-low reset (clears every register)
//   bus      slave side of fft_r22sdf_wm_pipe_if: ce_i, valid_i, ctr_i, conj_i, x_*_i, w_*_i,
//            ovf_clr_i in; valid_o, ctr_o, z_re_o, z_im_o, ovf_o out
module fft_r22sdf_wm_pipe #(
  parameter int DW            = 24,
  parameter int TWIDDLE_WIDTH = 10,
  parameter int NLOG2         = 10,
  parameter int ROUND         = 1,
  parameter int SATURATE      = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  fft_r22sdf_wm_pipe_if.slave     bus
);

  localparam int TW = TWIDDLE_WIDTH;
  localparam int EW = DW + 1;          // a-b
  localparam int CW = TW + 1;          // c-d, c+d
  localparam int PW = DW + TW + 1;     // full-precision products and sums
  localparam int SW = PW - (TW - 1);   // after the Q1.(TW-1) shift

  localparam logic signed [PW-1:0] RND = (ROUND != 0) ? PW'(64'd1 << (TW - 2)) : PW'(0);

  // Negating the most negative twiddle would wrap back onto itself; clamp it instead.
  function automatic logic signed [TW-1:0] neg_sat(input logic signed [TW-1:0] v);
    if (v == {1'b1, {(TW-1){1'b0}}})
      return {1'b0, {(TW-1){1'b1}}};
    return -v;
  endfunction

  function automatic logic signed [SW-1:0] scale(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] t;
    t = v + RND;
    return t[PW-1:TW-1];
  endfunction

  // Out of range when the bits above the DW sign bit are not all copies of it.
  function automatic logic out_of_range(input logic signed [SW-1:0] s);
    return !((&s[SW-1:DW-1]) || !(|s[SW-1:DW-1]));
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] s);
    if (out_of_range(s) && (SATURATE != 0))
      return s[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return s[DW-1:0];
  endfunction

  logic                 vld_p1, vld_p2, vld_p3, vld_p4;
  logic [NLOG2-1:0]     ctr_p1, ctr_p2, ctr_p3, ctr_p4;
  logic signed [DW-1:0] a_p1, b_p1, a_p2, b_p2;
  logic signed [TW-1:0] c_p1, d_p1, c_p2;
  logic signed [EW-1:0] e_p2;
  logic signed [CW-1:0] cmd_p2, cpd_p2;
  logic signed [PW-1:0] f_p3, pb_p3, pa_p3;
  logic signed [DW-1:0] z_re_p4, z_im_p4;
  logic                 ovf_q;

  logic signed [SW-1:0] re_s, im_s;
  logic                 ovf_now;

  always_comb begin
    re_s    = scale(pb_p3 + f_p3);
    im_s    = scale(pa_p3 - f_p3);
    ovf_now = vld_p3 && (out_of_range(re_s) || out_of_range(im_s));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      vld_p4  <= 1'b0;
      ctr_p1  <= '0;
      ctr_p2  <= '0;
      ctr_p3  <= '0;
      ctr_p4  <= '0;
      a_p1    <= '0;
      b_p1    <= '0;
      c_p1    <= '0;
      d_p1    <= '0;
      a_p2    <= '0;
      b_p2    <= '0;
      c_p2    <= '0;
      e_p2    <= '0;
      cmd_p2  <= '0;
      cpd_p2  <= '0;
      f_p3    <= '0;
      pb_p3   <= '0;
      pa_p3   <= '0;
      z_re_p4 <= '0;
      z_im_p4 <= '0;
    end else if (bus.ce_i) begin
      // S1: capture inputs, conjugate the twiddle here
      vld_p1 <= bus.valid_i;
      ctr_p1 <= bus.ctr_i;
      a_p1   <= bus.x_re_i;
      b_p1   <= bus.x_im_i;
      c_p1   <= bus.w_re_i;
      d_p1   <= bus.conj_i ? neg_sat(bus.w_im_i) : bus.w_im_i;
      // S2: pre-adds, one bit of growth each
      vld_p2 <= vld_p1;
      ctr_p2 <= ctr_p1;
      a_p2   <= a_p1;
      b_p2   <= b_p1;
      c_p2   <= c_p1;
      e_p2   <= EW'(a_p1) - EW'(b_p1);
      cmd_p2 <= CW'(c_p1) - CW'(d_p1);
      cpd_p2 <= CW'(c_p1) + CW'(d_p1);
      // S3: the three real products
      vld_p3 <= vld_p2;
      ctr_p3 <= ctr_p2;
      f_p3   <= PW'(c_p2) * PW'(e_p2);
      pb_p3  <= PW'(b_p2) * PW'(cmd_p2);
      pa_p3  <= PW'(a_p2) * PW'(cpd_p2);
      // S4: post-add, round, saturate
      vld_p4  <= vld_p3;
      ctr_p4  <= ctr_p3;
      z_re_p4 <= sat(re_s);
      z_im_p4 <= sat(im_s);
    end
  end

  // Clear wins over a same-cycle set and works regardless of ce_i.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      ovf_q <= 1'b0;
    else if (bus.ovf_clr_i)
      ovf_q <= 1'b0;
    else if (bus.ce_i && ovf_now)
      ovf_q <= 1'b1;
  end

  assign bus.valid_o = vld_p4;
  assign bus.ctr_o   = ctr_p4;
  assign bus.z_re_o  = z_re_p4;
  assign bus.z_im_o  = z_im_p4;
  assign bus.ovf_o   = ovf_q;

endmodule

// File: tb/tb_fft_r22sdf_wm_pipe.sv
module tb_fft_r22sdf_wm_pipe;
  localparam int DW = 24;
  localparam int TW = 10;
  localparam int NL = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fft_r22sdf_wm_pipe_if #(.DW(DW), .TWIDDLE_WIDTH(TW), .NLOG2(NL)) bus0 ();
  fft_r22sdf_wm_pipe_if #(.DW(DW), .TWIDDLE_WIDTH(TW), .NLOG2(NL)) bus1 ();

  fft_r22sdf_wm_pipe #(.DW(DW), .TWIDDLE_WIDTH(TW), .NLOG2(NL), .ROUND(1), .SATURATE(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus0.slave));

  fft_r22sdf_wm_pipe #(.DW(DW), .TWIDDLE_WIDTH(TW), .NLOG2(NL), .ROUND(0), .SATURATE(1)) dut_trunc (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus1.slave));

  assign bus1.ce_i      = bus0.ce_i;
  assign bus1.valid_i   = bus0.valid_i;
  assign bus1.ctr_i     = bus0.ctr_i;
  assign bus1.conj_i    = bus0.conj_i;
  assign bus1.x_re_i    = bus0.x_re_i;
  assign bus1.x_im_i    = bus0.x_im_i;
  assign bus1.w_re_i    = bus0.w_re_i;
  assign bus1.w_im_i    = bus0.w_im_i;
  assign bus1.ovf_clr_i = bus0.ovf_clr_i;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int xr, input int xi, input int wr, input int wi,
                       input logic cj, input int ctr);
    bus0.x_re_i  = DW'(xr);
    bus0.x_im_i  = DW'(xi);
    bus0.w_re_i  = TW'(wr);
    bus0.w_im_i  = TW'(wi);
    bus0.conj_i  = cj;
    bus0.ctr_i   = NL'(ctr);
    bus0.valid_i = 1'b1;
  endtask

  // One valid sample, then three more edges so the result sits on the outputs.
  task automatic send_and_wait(input int xr, input int xi, input int wr, input int wi,
                               input logic cj, input int ctr);
    drive(xr, xi, wr, wi, cj, ctr);
    tick();
    bus0.valid_i = 1'b0;
    tick();
    tick();
    chk("no_early_valid", bus0.valid_o, 0);
    tick();
  endtask

  // Direct (non-Karatsuba) reference for the stream: w = (511, 0), x = (100*i-700, 0).
  function automatic int model_re(input int i);
    int x;
    x = 100 * i - 700;
    return (x * 511 + 256) >>> 9;
  endfunction

  initial begin
    int sent;
    int got;
    bus0.ce_i      = 1'b1;
    bus0.ovf_clr_i = 1'b0;
    bus0.valid_i   = 1'b0;
    bus0.conj_i    = 1'b0;
    bus0.ctr_i     = '0;
    bus0.x_re_i    = '0;
    bus0.x_im_i    = '0;
    bus0.w_re_i    = '0;
    bus0.w_im_i    = '0;

    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_valid", bus0.valid_o, 0);
    chk("rst_ctr",   bus0.ctr_o,   0);
    chk("rst_zre",   bus0.z_re_o,  0);
    chk("rst_zim",   bus0.z_im_o,  0);
    chk("rst_ovf",   bus0.ovf_o,   0);
    rst_n = 1'b1;
    tick();

    // Real-only twiddle, rounded and truncated variants
    send_and_wait(1000, -2000, 511, 0, 1'b0, 5);
    chk("t1_valid", bus0.valid_o, 1);
    chk("t1_ctr",   bus0.ctr_o,   5);
    chk("t1_zre",   bus0.z_re_o,  998);
    chk("t1_zim",   bus0.z_im_o,  -1996);
    chk("t1_ovf",   bus0.ovf_o,   0);
    chk("t1_trunc_zre", bus1.z_re_o, 998);
    chk("t1_trunc_zim", bus1.z_im_o, -1997);
    tick();
    chk("t1_valid_pulse", bus0.valid_o, 0);

    // Imaginary twiddle, forward and conjugated
    send_and_wait(1000, 0, 0, 511, 1'b0, 6);
    chk("t2_zre", bus0.z_re_o, 0);
    chk("t2_zim", bus0.z_im_o, 998);
    send_and_wait(1000, 0, 0, 511, 1'b1, 7);
    chk("t3_zre", bus0.z_re_o, 0);
    chk("t3_zim", bus0.z_im_o, -998);

    // Conjugating w_im = -512 clamps to +511
    send_and_wait(1000, 0, 0, -512, 1'b1, 8);
    chk("conj_sat_zim", bus0.z_im_o, 998);
    chk("conj_sat_ovf", bus0.ovf_o,  0);

    // Overflow: saturate and set sticky flag
    send_and_wait(-8388608, -8388608, -512, -512, 1'b0, 9);
    chk("ovf_zre",  bus0.z_re_o, 0);
    chk("ovf_zim",  bus0.z_im_o, 8388607);
    chk("ovf_set",  bus0.ovf_o,  1);
    tick();
    tick();
    chk("ovf_sticky", bus0.ovf_o, 1);
    bus0.ce_i      = 1'b0;
    bus0.ovf_clr_i = 1'b1;
    tick();
    bus0.ovf_clr_i = 1'b0;
    bus0.ce_i      = 1'b1;
    chk("ovf_clr", bus0.ovf_o, 0);
    // Invalid slots carrying the same overflowing data must not set the flag
    for (int k = 0; k < 5; k++) tick();
    chk("ovf_invalid_ignored", bus0.ovf_o, 0);

    // Back-to-back stream with a 3-cycle ce stall
    sent = 0;
    got  = 0;
    for (int k = 0; k < 30; k++) begin
      bus0.ce_i = !(k >= 8 && k <= 10);
      if (sent < 16) drive(100 * sent - 700, 0, 511, 0, 1'b0, sent);
      else bus0.valid_i = 1'b0;
      tick();
      if (bus0.ce_i) begin
        if (sent < 16) sent++;
        if (bus0.valid_o) begin
          chk("stream_ctr", bus0.ctr_o,  got);
          chk("stream_zre", bus0.z_re_o, model_re(got));
          chk("stream_zim", bus0.z_im_o, 0);
          got++;
        end
      end else begin
        chk("stall_valid", bus0.valid_o, 1);
        chk("stall_ctr",   bus0.ctr_o,   got - 1);
        chk("stall_zre",   bus0.z_re_o,  model_re(got - 1));
      end
    end
    bus0.ce_i = 1'b1;
    chk("stream_count", got, 16);

    // Reset with samples in flight
    for (int i = 0; i < 4; i++) begin
      drive(2000 + i, 0, 511, 0, 1'b0, 20 + i);
      tick();
    end
    chk("pre_rst_valid", bus0.valid_o, 1);
    chk("pre_rst_zre",   bus0.z_re_o,  1996);
    bus0.valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", bus0.valid_o, 0);
    chk("rst_async_zre",   bus0.z_re_o,  0);
    chk("rst_async_ctr",   bus0.ctr_o,   0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("no_stale_valid", bus0.valid_o, 0);
    end
    send_and_wait(1000, -2000, 511, 0, 1'b0, 9);
    chk("post_rst_valid", bus0.valid_o, 1);
    chk("post_rst_ctr",   bus0.ctr_o,   9);
    chk("post_rst_zim",   bus0.z_im_o,  -1996);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
